// File: rtl/xor_arbiter_puf_ctrl.sv
// K-chain XOR arbiter PUF with a majority-vote sequencer and start/valid handshake.
// Optional macro PUF_SIM_MODEL_EN swaps the chains for a deterministic masked-parity model.

`ifndef PUF_SIM_MODEL_EN
module puf_mux_stage (
  input  logic sel,
  input  logic in_top,
  input  logic in_bot,
  output logic out_top,
  output logic out_bot
);
  assign out_top = sel ? in_bot : in_top;
  assign out_bot = sel ? in_top : in_bot;
endmodule

module puf_arbiter_flop (
  input  logic path_a,
  input  logic path_b,
  output logic q
);
  // The late-arriving path clocks the early one: q=1 means path_a won the race.
  always_ff @(posedge path_b) begin
    q <= path_a;
  end
endmodule
`endif

module xor_arbiter_puf_ctrl #(
  parameter int STAGES = 128,
  parameter int K      = 4,
  parameter int SETTLE = 8,
  parameter int VOTES  = 5,
  parameter logic [STAGES-1:0] MASK = {STAGES{1'b1}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [STAGES-1:0]          chal,
  output logic                       busy,
  output logic                       resp,
  output logic                       resp_valid,
  output logic                       resp_stable,
  output logic [$clog2(VOTES+1)-1:0] ones_count
);

  localparam int VW = $clog2(VOTES + 1);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [VW-1:0] VOTES_V     = VW'(VOTES);
  localparam logic [VW-1:0] HALF_V      = VW'(VOTES / 2);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PRECHARGE = 3'd1;
  localparam logic [2:0] S_LAUNCH    = 3'd2;
  localparam logic [2:0] S_SETTLE_W  = 3'd3;
  localparam logic [2:0] S_SAMPLE    = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  if (VOTES < 1 || (VOTES % 2) == 0 || K < 1 || SETTLE < 1 || STAGES < 2) begin : g_bad_params
    $error("xor_arbiter_puf_ctrl: illegal parameters (VOTES odd >=1, K>=1, SETTLE>=1, STAGES>=2)");
  end

  logic [2:0]        state;
  logic [STAGES-1:0] chal_q;
  logic              race;
  logic [SW-1:0]     settle_cnt;
  logic [VW-1:0]     ones;
  logic [VW-1:0]     evals;
  logic [K-1:0]      raw;
  logic              eval_bit;
  logic              accept;

  assign eval_bit = ^raw;
  // DONE already has busy low, so a start there is taken on the DONE->IDLE edge.
  assign accept   = start && (state == S_IDLE || state == S_DONE);

`ifdef PUF_SIM_MODEL_EN
  for (genvar k = 0; k < K; k++) begin : g_model
    localparam int R = k % STAGES;
    localparam logic [STAGES-1:0] ROT = (R == 0) ? MASK : ((MASK << R) | (MASK >> (STAGES - R)));
    assign raw[k] = race & (^(chal_q & ROT));
  end
`else
  for (genvar k = 0; k < K; k++) begin : g_chain
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
      logic top;
      logic bot;
      if (s == 0) begin : g_first
        puf_mux_stage u_mux (
          .sel     (chal_q[s]),
          .in_top  (race),
          .in_bot  (race),
          .out_top (top),
          .out_bot (bot)
        );
      end else begin : g_next
        puf_mux_stage u_mux (
          .sel     (chal_q[s]),
          .in_top  (g_stage[s-1].top),
          .in_bot  (g_stage[s-1].bot),
          .out_top (top),
          .out_bot (bot)
        );
      end
    end
    puf_arbiter_flop u_arb (
      .path_a (g_stage[STAGES-1].top),
      .path_b (g_stage[STAGES-1].bot),
      .q      (raw[k])
    );
  end
`endif

  // Sequencer: one precharge/launch/settle/sample pass per vote.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      chal_q     <= '0;
      race       <= 1'b0;
      settle_cnt <= '0;
      ones       <= '0;
      evals      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            chal_q <= chal;
            ones   <= '0;
            evals  <= '0;
            race   <= 1'b0;
            state  <= S_PRECHARGE;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_PRECHARGE: begin
          race  <= 1'b1;
          state <= S_LAUNCH;
        end
        S_LAUNCH: begin
          settle_cnt <= SETTLE_LOAD;
          state      <= S_SETTLE_W;
        end
        S_SETTLE_W: begin
          if (settle_cnt == '0) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_SAMPLE: begin
          ones  <= ones + VW'(eval_bit);
          evals <= evals + VW'(1);
          race  <= 1'b0;
          if (evals + VW'(1) == VOTES_V) begin
            state <= S_DONE;
          end else begin
            state <= S_PRECHARGE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign resp_valid  = (state == S_DONE);
  assign resp        = resp_valid && (ones > HALF_V);
  assign resp_stable = resp_valid && (ones == '0 || ones == VOTES_V);
  assign ones_count  = resp_valid ? ones : '0;

endmodule

// File: tb/tb_xor_arbiter_puf_ctrl.sv
// Scoreboard bench for xor_arbiter_puf_ctrl: two instances (K=1 mask FF, K=2 mask 0F) share stimulus.
// Exact response values are checked when PUF_SIM_MODEL_EN is defined; otherwise vote/flag consistency.

module tb_xor_arbiter_puf_ctrl;

  localparam int STAGES  = 8;
  localparam int SETTLE  = 4;
  localparam int VOTES   = 3;
  localparam int K_A     = 1;
  localparam int K_B     = 2;
  localparam logic [7:0] MASK_A = 8'hFF;
  localparam logic [7:0] MASK_B = 8'h0F;
  localparam int LAT     = VOTES * (SETTLE + 3);
  localparam int SPACING = LAT + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] chal = 8'h00;

  logic       busy_a, resp_a, valid_a, stable_a;
  logic [1:0] ones_a;
  logic       busy_b, resp_b, valid_b, stable_b;
  logic [1:0] ones_b;

  xor_arbiter_puf_ctrl #(
    .STAGES (STAGES), .K (K_A), .SETTLE (SETTLE), .VOTES (VOTES), .MASK (MASK_A)
  ) dut_a (
    .clk (clk), .rst (rst), .start (start), .chal (chal),
    .busy (busy_a), .resp (resp_a), .resp_valid (valid_a),
    .resp_stable (stable_a), .ones_count (ones_a)
  );

  xor_arbiter_puf_ctrl #(
    .STAGES (STAGES), .K (K_B), .SETTLE (SETTLE), .VOTES (VOTES), .MASK (MASK_B)
  ) dut_b (
    .clk (clk), .rst (rst), .start (start), .chal (chal),
    .busy (busy_b), .resp (resp_b), .resp_valid (valid_b),
    .resp_stable (stable_b), .ones_count (ones_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int resp_a;
    int ones_a;
    int stable_a;
    int resp_b;
    int ones_b;
    int stable_b;
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   next_ok = 0;
  int   tests = 0;
  int   errors = 0;
  bit   checking = 1'b0;

  task automatic check_output(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, actual, expected);
    end
  endtask

  // Parity of the challenge under the mask rotated left by k.
  function automatic int chain_bit(input logic [7:0] c, input logic [7:0] m, input int k);
    int cnt = 0;
    for (int i = 0; i < STAGES; i++) begin
      if (c[i] && m[(i - (k % STAGES) + STAGES) % STAGES]) cnt++;
    end
    return cnt % 2;
  endfunction

  function automatic int votes_ones(input logic [7:0] c, input logic [7:0] m, input int nchains);
    int x = 0;
    int n = 0;
    for (int k = 0; k < nchains; k++) x = x ^ chain_bit(c, m, k);
    for (int v = 0; v < VOTES; v++) n += x;
    return n;
  endfunction

  function automatic exp_t make_exp(input logic [7:0] c, input int due);
    exp_t e;
    e.due      = due;
    e.ones_a   = votes_ones(c, MASK_A, K_A);
    e.resp_a   = int'(e.ones_a > VOTES / 2);
    e.stable_a = int'(e.ones_a == 0 || e.ones_a == VOTES);
    e.ones_b   = votes_ones(c, MASK_B, K_B);
    e.resp_b   = int'(e.ones_b > VOTES / 2);
    e.stable_b = int'(e.ones_b == 0 || e.ones_b == VOTES);
    return e;
  endfunction

  // Reference model: decides at each edge whether a request is accepted and when it answers.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (rst) begin
      sb.delete();
      next_ok <= cycle + 2;
    end else if (start && (cycle + 1) >= next_ok) begin
      sb.push_back(make_exp(chal, cycle + 1 + LAT));
      next_ok <= cycle + 1 + SPACING;
    end
  end

  // Monitor: compares handshake every cycle and pops the scoreboard on each expected response.
  always @(negedge clk) begin
    if (checking) begin
      automatic bit exp_valid = (sb.size() > 0) && (sb[0].due == cycle);
      automatic bit exp_busy  = (sb.size() > 0) && (cycle < sb[0].due);
      check_output("busy_a", int'(busy_a), int'(exp_busy));
      check_output("busy_b", int'(busy_b), int'(exp_busy));
      check_output("valid_a", int'(valid_a), int'(exp_valid));
      check_output("valid_b", int'(valid_b), int'(exp_valid));
      if (exp_valid) begin
        automatic exp_t e = sb.pop_front();
`ifdef PUF_SIM_MODEL_EN
        check_output("resp_a", int'(resp_a), e.resp_a);
        check_output("ones_a", int'(ones_a), e.ones_a);
        check_output("stable_a", int'(stable_a), e.stable_a);
        check_output("resp_b", int'(resp_b), e.resp_b);
        check_output("ones_b", int'(ones_b), e.ones_b);
        check_output("stable_b", int'(stable_b), e.stable_b);
`else
        check_output("vote_a", int'(resp_a), int'(int'(ones_a) > VOTES / 2));
        check_output("flag_a", int'(stable_a), int'(ones_a == 2'd0 || int'(ones_a) == VOTES));
        check_output("vote_b", int'(resp_b), int'(int'(ones_b) > VOTES / 2));
        check_output("flag_b", int'(stable_b), int'(ones_b == 2'd0 || int'(ones_b) == VOTES));
        check_output("due_a", e.due, cycle);
`endif
      end
    end
  end

  task automatic apply_stimulus(input logic [7:0] c);
    @(negedge clk);
    chal  = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_output("rst_busy", int'(busy_a | busy_b), 0);
    check_output("rst_valid", int'(valid_a | valid_b), 0);
    check_output("rst_resp", int'(resp_a | resp_b), 0);
    check_output("rst_stable", int'(stable_a | stable_b), 0);
    check_output("rst_ones", int'(ones_a | ones_b), 0);
    checking = 1'b1;

    apply_stimulus(8'h01);
    repeat (30) @(negedge clk);
    apply_stimulus(8'h10);
    repeat (30) @(negedge clk);
    apply_stimulus(8'h03);
    repeat (30) @(negedge clk);

    // A second start five cycles after the accept must be dropped.
    apply_stimulus(8'h5C);
    repeat (4) @(negedge clk);
    chal  = 8'hAA;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);

    // Reset during the second evaluation's settle window aborts the request.
    apply_stimulus(8'h0F);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    apply_stimulus(8'h03);
    repeat (30) @(negedge clk);

    // start held high: back-to-back accepts at minimum spacing.
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 75; i++) begin
      chal = 8'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (30) @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      apply_stimulus(8'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    check_output("drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
